// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - state encodings, LED patterns and digit helpers for the code lock
package lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'b00,
    ST_OPEN    = 2'b01,
    ST_LOCKOUT = 2'b10
  } state_t;

  localparam logic [3:0] LED_OPEN  = 4'b1111;
  localparam logic [3:0] LED_ALARM = 4'b1001;
  localparam logic [3:0] LED_OFF   = 4'b0000;

  // Digit k of the code, first digit in the top nibble.
  function automatic logic [3:0] code_digit(input logic [15:0] code, input int k);
    logic [15:0] s;
    s = code << (4 * k);
    return s[15:12];
  endfunction

  function automatic logic [3:0] thermo(input int n);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter shared by the open and lockout phases
module lock_timer #(
  parameter int W = 8
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         iload,
  input  logic [W-1:0] ivalue,
  input  logic         ien,
  output logic         ozero
);

  logic [W-1:0] count;

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge iclk) begin
    if (irst) begin
      count <= '0;
    end else if (iload) begin
      count <= ivalue;
    end else if (ien && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign ozero = (count == '0);

endmodule

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - multi-digit code entry with open timeout and wrong-code lockout
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter logic [15:0] CODE           = 16'hA5C3,
  parameter int          MAX_TRIES      = 3,
  parameter int          OPEN_CYCLES    = 100_000_000,
  parameter int          LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic [3:0] isw,
  input  logic       ibtn,
  output logic [3:0] oled,
  output logic       oopen,
  output logic       oalarm
);

  localparam int IW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX);

  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   idx;
  logic            err;
  logic [FW-1:0]   fails;
  logic            btn_q;
  logic            press;
  logic            digit_ok;
  logic            last_digit;
  logic            code_ok;
  logic            lock_trip;
  logic            t_load;
  logic [TW-1:0]   t_value;
  logic            t_zero;

  assign press      = ibtn & ~btn_q;
  assign digit_ok   = (isw == code_digit(CODE, int'(idx)));
  assign last_digit = (idx == IW'(CODE_LEN - 1));
  assign code_ok    = ~err & digit_ok;
  assign lock_trip  = ((int'(fails) + 1) == MAX_TRIES);

  lock_timer #(.W(TW)) u_timer (
    .iclk   (iclk),
    .irst   (irst),
    .iload  (t_load),
    .ivalue (t_value),
    .ien    (1'b1),
    .ozero  (t_zero)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state <= ST_ENTRY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    t_load     = 1'b0;
    t_value    = T_OPEN;
    case (state)
      ST_ENTRY: begin
        if (press && last_digit) begin
          if (code_ok) begin
            next_state = ST_OPEN;
            t_load     = 1'b1;
            t_value    = T_OPEN;
          end else if (lock_trip) begin
            next_state = ST_LOCKOUT;
            t_load     = 1'b1;
            t_value    = T_LOCK;
          end
        end
      end
      ST_OPEN: begin
        if (press || t_zero) next_state = ST_ENTRY;
      end
      ST_LOCKOUT: begin
        if (t_zero) next_state = ST_ENTRY;
      end
      default: next_state = ST_ENTRY;
    endcase
  end

  // Digit bookkeeping only moves on presses seen in ST_ENTRY; btn_q tracks in every state.
  always_ff @(posedge iclk) begin
    if (irst) begin
      idx   <= '0;
      err   <= 1'b0;
      fails <= '0;
      btn_q <= 1'b0;
    end else begin
      btn_q <= ibtn;
      if ((state == ST_ENTRY) && press) begin
        if (last_digit) begin
          idx <= '0;
          err <= 1'b0;
          if (code_ok || lock_trip) begin
            fails <= '0;
          end else begin
            fails <= fails + FW'(1);
          end
        end else begin
          idx <= idx + IW'(1);
          if (!digit_ok) err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    oled   = LED_OFF;
    oopen  = 1'b0;
    oalarm = 1'b0;
    case (state)
      ST_ENTRY:   oled = thermo(int'(idx));
      ST_OPEN: begin
        oled  = LED_OPEN;
        oopen = 1'b1;
      end
      ST_LOCKOUT: begin
        oled   = LED_ALARM;
        oalarm = 1'b1;
      end
      default:    oled = LED_OFF;
    endcase
  end

  a_exclusive: assert property (@(posedge iclk) disable iff (irst) !(oopen && oalarm));
  a_idx_range: assert property (@(posedge iclk) disable iff (irst) (int'(idx) < CODE_LEN));

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - scoreboard bench for lock_sequencer
module tb_lock_sequencer;

  localparam logic [15:0] CODE           = 16'hA5C3;
  localparam int          CODE_LEN       = 4;
  localparam int          MAX_TRIES      = 3;
  localparam int          OPEN_CYCLES    = 20;
  localparam int          LOCKOUT_CYCLES = 50;
  localparam logic [15:0] GOOD           = 16'hA5C3;
  localparam logic [15:0] BAD            = 16'hA5C4;

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic       ibtn = 1'b0;
  logic [3:0] isw  = 4'h0;
  logic [3:0] oled;
  logic       oopen;
  logic       oalarm;

  lock_sequencer #(
    .CODE_LEN       (CODE_LEN),
    .CODE           (CODE),
    .MAX_TRIES      (MAX_TRIES),
    .OPEN_CYCLES    (OPEN_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .iclk   (iclk),
    .irst   (irst),
    .isw    (isw),
    .ibtn   (ibtn),
    .oled   (oled),
    .oopen  (oopen),
    .oalarm (oalarm)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [5:0] exp;
    int         step;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         step_no = 0;
  int         n;

  int         m_state = 0;
  int         m_idx   = 0;
  int         m_fails = 0;
  int         m_left  = 0;
  logic       m_err   = 1'b0;
  logic       m_btnq  = 1'b0;
  logic [3:0] digits [4] = '{4'hA, 4'h5, 4'hC, 4'h3};

  logic [3:0] last_led;
  logic       last_open;
  logic       last_alarm;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [5:0] model_out();
    case (m_state)
      1:       return {4'hF, 1'b1, 1'b0};
      2:       return {4'h9, 1'b0, 1'b1};
      default: return {4'((1 << m_idx) - 1), 2'b00};
    endcase
  endfunction

  always @(posedge iclk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq($sformatf("out@%0d", e.step), {26'd0, oled, oopen, oalarm}, {26'd0, e.exp});
    end
  end

  // One clock: drive at negedge, advance the reference model, queue its expected outputs.
  task automatic cyc(input logic rst, input logic btn, input logic [3:0] sw);
    logic pr;
    logic ok;
    @(negedge iclk);
    irst = rst;
    ibtn = btn;
    isw  = sw;
    pr   = btn & ~m_btnq;
    if (rst) begin
      m_state = 0; m_idx = 0; m_err = 1'b0; m_fails = 0; m_btnq = 1'b0;
    end else begin
      case (m_state)
        0: if (pr) begin
          ok = !m_err && (sw == digits[m_idx]);
          if (m_idx == CODE_LEN - 1) begin
            if (ok) begin
              m_state = 1; m_left = OPEN_CYCLES; m_fails = 0;
            end else if (m_fails + 1 == MAX_TRIES) begin
              m_state = 2; m_left = LOCKOUT_CYCLES; m_fails = 0;
            end else begin
              m_fails++;
            end
            m_idx = 0;
            m_err = 1'b0;
          end else begin
            if (sw != digits[m_idx]) m_err = 1'b1;
            m_idx++;
          end
        end
        1: if (pr || m_left == 1) m_state = 0; else m_left--;
        default: if (m_left == 1) m_state = 0; else m_left--;
      endcase
      m_btnq = btn;
    end
    step_no++;
    sb.push_back('{exp: model_out(), step: step_no});
    @(posedge iclk);
    #2;
  endtask

  task automatic press(input logic [3:0] sw);
    cyc(1'b0, 1'b1, sw);
    last_led   = oled;
    last_open  = oopen;
    last_alarm = oalarm;
    cyc(1'b0, 1'b0, sw);
  endtask

  task automatic enter(input logic [15:0] code);
    for (int i = 0; i < 4; i++) press(code[15-4*i -: 4]);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);
    check_eq("rst_led", oled, 4'b0000);
    check_eq("rst_open", oopen, 1'b0);
    check_eq("rst_alarm", oalarm, 1'b0);
    cyc(1'b0, 1'b0, 4'h0);

    press(4'hA); check_eq("t1_d1", last_led, 4'b0001);
    press(4'h5); check_eq("t1_d2", last_led, 4'b0011);
    press(4'hC); check_eq("t1_d3", last_led, 4'b0111);
    press(4'h3); check_eq("t1_d4", last_led, 4'b1111);
    check_eq("t1_open", last_open, 1'b1);
    n = int'(last_open) + int'(oopen);
    for (int k = 0; k < 60 && oopen; k++) begin
      cyc(1'b0, 1'b0, 4'h0);
      if (oopen) n++;
    end
    check_eq("t1_open_len", n, OPEN_CYCLES);
    check_eq("t1_relock_led", oled, 4'b0000);

    enter(GOOD);
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'hA);
    check_eq("t2_relock_open", oopen, 1'b0);
    check_eq("t2_relock_led", oled, 4'b0000);
    cyc(1'b0, 1'b0, 4'hA);
    check_eq("t2_no_digit", oled, 4'b0000);

    enter(GOOD);
    for (int k = 0; k < OPEN_CYCLES - 2; k++) cyc(1'b0, 1'b0, 4'h0);
    check_eq("t2_last_open", oopen, 1'b1);
    cyc(1'b0, 1'b1, 4'hA);
    check_eq("t2_zero_press", {oled, oopen}, 5'b00000);
    cyc(1'b0, 1'b0, 4'hA);

    enter(BAD);
    enter(BAD);
    check_eq("t3_no_lock_2", oalarm, 1'b0);
    enter(BAD);
    check_eq("t3_alarm", last_alarm, 1'b1);
    check_eq("t3_alarm_led", last_led, 4'b1001);
    n = int'(last_alarm) + int'(oalarm);
    for (int k = 0; k < 100 && oalarm; k++) begin
      cyc(1'b0, logic'((k % 3 == 0) && (k < 40)), 4'hA);
      if (oalarm) n++;
    end
    check_eq("t3_lock_len", n, LOCKOUT_CYCLES);
    check_eq("t3_exit_led", oled, 4'b0000);
    enter(BAD);
    check_eq("t3_one_wrong", {oalarm, oled}, 5'b00000);

    do_reset();
    enter(BAD);
    enter(BAD);
    enter(GOOD);
    check_eq("t4_open", last_open, 1'b1);
    for (int k = 0; k < 40 && oopen; k++) cyc(1'b0, 1'b0, 4'h0);
    enter(BAD);
    enter(BAD);
    check_eq("t4_no_lock", oalarm, 1'b0);
    check_eq("t4_led", oled, 4'b0000);

    do_reset();
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 4'hA);
    cyc(1'b0, 1'b0, 4'hA);
    check_eq("t5_held_idx", oled, 4'b0001);
    do_reset();
    enter(BAD);
    enter(BAD);
    enter(BAD);
    for (int k = 0; k < 100 && oalarm; k++) cyc(1'b0, 1'b1, 4'hA);
    check_eq("t5_lock_done", oalarm, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'hA);
    check_eq("t5_hold_exit", oled, 4'b0000);
    cyc(1'b0, 1'b0, 4'hA);

    do_reset();
    enter(GOOD);
    check_eq("t6_open", oopen, 1'b1);
    cyc(1'b1, 1'b0, 4'h0);
    check_eq("t6_rst_open", {oled, oopen, oalarm}, 6'b000000);
    cyc(1'b0, 1'b0, 4'h0);
    press(4'hA);
    press(4'h5);
    check_eq("t6_idx2", oled, 4'b0011);
    cyc(1'b1, 1'b0, 4'h0);
    check_eq("t6_rst_idx", {oled, oopen, oalarm}, 6'b000000);
    cyc(1'b0, 1'b0, 4'h0);
    press(4'hC);
    press(4'h3);
    check_eq("t6_partial", {oled, oopen}, 5'b00110);
    press(4'hA);
    press(4'h5);
    check_eq("t6_no_open", last_open, 1'b0);
    enter(GOOD);
    check_eq("t6_full_open", last_open, 1'b1);

    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 4'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Multi-digit code-entry controller for the board lock demo.
- Sequences user input into code-entry, open and lockout phases, and drives the status LEDs.
- Each digit is entered by setting the 4 switches and confirming with a button press.
- Adds wrong-attempt counting, a timed lockout and an automatic relock timeout.

Parameters:
- CODE_LEN, 4: digits per code (1..4).
- CODE, 16'hA5C3: secret code. Digit k (k = 0 first) is CODE[15-4k -: 4]. Only the first CODE_LEN digits are used.
- MAX_TRIES, 3: consecutive wrong codes before lockout (>= 1).
- OPEN_CYCLES, 100_000_000: cycles the lock stays open before auto-relock (>= 2).
- LOCKOUT_CYCLES, 500_000_000: cycles spent in lockout (>= 2).

Ports:
- iclk, in, 1: system clock. Single clock domain.
- irst, in, 1: synchronous, active-high reset.
- isw, in, 4: digit value. Synchronous to iclk.
- ibtn, in, 1: confirm/relock button. Already debounced and synchronous to iclk.
- oled, out, 4: status LEDs.
- oopen, out, 1: lock open.
- oalarm, out, 1: lockout active.

Behaviour:
- Button edge detect
  - Register ibtn into btn_q.
  - press = ibtn & ~btn_q.
  - Only press events act. A held button never repeats.
  - btn_q updates in every state, including LOCKOUT, so a button held across a state change produces no press.
- States: ST_ENTRY, ST_OPEN, ST_LOCKOUT.
  - 2-bit state register.
  - Moore outputs, decoded combinationally from registered state and counters only.
- Reset (irst=1 at a posedge)
  - state=ST_ENTRY, digit index idx=0, mismatch flag err=0, fail count fails=0, timer=0, btn_q=0.
  - Output values while in reset: oled=0000, oopen=0, oalarm=0.
  - Reset mid-operation (open or lockout) aborts immediately with the same values.
- ST_ENTRY
  - On press: compare isw against digit idx. If unequal, err<=1. Then idx<=idx+1.
  - On the press where idx==CODE_LEN-1 (last digit), the code is evaluated with that digit's comparison included.
    - Correct: state<=ST_OPEN, fails<=0, timer<=OPEN_CYCLES-1.
    - Wrong: fails<=fails+1.
      - If fails+1==MAX_TRIES: state<=ST_LOCKOUT, timer<=LOCKOUT_CYCLES-1, fails<=0.
      - Else remain in ST_ENTRY.
    - In every case idx<=0 and err<=0.
  - No indication of which digit failed. A wrong code always consumes all CODE_LEN presses.
- ST_OPEN
  - timer decrements each cycle.
  - Leave to ST_ENTRY when press occurs or timer==0, whichever comes first.
  - Open lasts exactly OPEN_CYCLES cycles absent a press.
  - Press in the same cycle as timer==0: single transition to ST_ENTRY, no other effect.
  - A press never counts as a digit in this state.
- ST_LOCKOUT
  - Presses are ignored.
  - timer decrements each cycle. At timer==0, go to ST_ENTRY.
  - Lockout lasts exactly LOCKOUT_CYCLES cycles.
- Outputs
  - ST_ENTRY: oled = thermometer of idx (idx=2 gives 0011), oopen=0, oalarm=0.
  - ST_OPEN: oled=1111, oopen=1, oalarm=0.
  - ST_LOCKOUT: oled=1001, oopen=0, oalarm=1.
- Widths
  - idx: $clog2(CODE_LEN+1) bits.
  - fails: $clog2(MAX_TRIES+1) bits.
  - timer: $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)) bits.
  - No wrap-around is reachable.

Decomposition:
- Package lock_pkg holds:
  - state encodings ST_ENTRY=2'b00, ST_OPEN=2'b01, ST_LOCKOUT=2'b10;
  - LED pattern constants LED_OPEN=4'b1111 and LED_ALARM=4'b1001.
- One sub-module, lock_timer, shared by ST_OPEN and ST_LOCKOUT:
  - loadable down-counter with inputs iclk, irst, iload, ivalue, ien and output ozero;
  - synchronous reset to 0.
- State machine, edge detect and digit comparison stay in lock_sequencer.

Test Plan:
Bench parameters: CODE=16'hA5C3, CODE_LEN=4, MAX_TRIES=3, OPEN_CYCLES=20, LOCKOUT_CYCLES=50.
1. Correct entry: press with isw=A,5,C,3 -> oled 0001, 0011, 0111, then 1111 with oopen=1 the cycle after the 4th press. Relocks (oled=0000) exactly 20 cycles later.
2. Manual relock: open, then press at cycle 5 of open -> ST_ENTRY next cycle, oopen=0. The same press does not advance idx (oled=0000).
3. Lockout: three codes A,5,C,4 -> after the 12th press oalarm=1, oled=1001 for exactly 50 cycles. Presses during lockout are ignored. Afterwards ST_ENTRY with fails=0: one wrong code does not re-lock.
4. Fail reset: two wrong codes, then the correct code -> open, and fails=0. Two further wrong codes do not trigger lockout.
5. Held button: hold ibtn for 10 cycles with isw=A -> idx advances by 1 only. Holding ibtn while lockout ends -> no press on exit.
6. Mid-operation reset: assert irst while open, and again at idx=2 -> next cycle oled=0000, oopen=0, oalarm=0. A full correct code is then required to open.
